// File: rtl/z_buffer_stage.sv
// Purpose : depth-test and storage stage for arbitrated pixels, with a clear sweep and a display readout port.
// Latency : a pixel is looked up one cycle after acceptance and written the cycle after that; readout data appears 1 cycle after rd_en.
// Backpr. : rdy_z_buffer is high only in IDLE (low 2 cycles after each acceptance and during a sweep); a send while not ready is dropped and sets drop_err.
//
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   pix_in, send_z_buffer           pixel {x,y,depth,color} and its valid from the arbiter
//   rdy_z_buffer                    stage can accept a pixel this cycle
//   clear_req, clear_busy           clear sweep request pulse / sweep in progress
//   drop_err                        sticky protocol-violation flag
//   rd_en, rd_addr                  readout request and {x,y} address
//   rd_valid, rd_depth, rd_color    readout response (data holds while rd_valid=0)
// Optional build macro ZBUF_STATS_EN adds stat_written / stat_rejected counters.
module z_buffer_stage #(
    parameter int X_WIDTH     = 4,
    parameter int Y_WIDTH     = 4,
    parameter int DEPTH_WIDTH = 8,
    parameter int COLOR_WIDTH = 8,
    parameter int PIXEL_WIDTH = X_WIDTH + Y_WIDTH + DEPTH_WIDTH + COLOR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PIXEL_WIDTH-1:0]     pix_in,
    input  logic                       send_z_buffer,
    output logic                       rdy_z_buffer,
    input  logic                       clear_req,
    output logic                       clear_busy,
    output logic                       drop_err,
    input  logic                       rd_en,
    input  logic [X_WIDTH+Y_WIDTH-1:0] rd_addr,
    output logic                       rd_valid,
    output logic [DEPTH_WIDTH-1:0]     rd_depth,
    output logic [COLOR_WIDTH-1:0]     rd_color
`ifdef ZBUF_STATS_EN
    ,
    output logic [15:0]                stat_written,
    output logic [15:0]                stat_rejected
`endif
);

    localparam int ADDR_W  = X_WIDTH + Y_WIDTH;
    localparam int ENT_W   = DEPTH_WIDTH + COLOR_WIDTH;
    localparam int NUM_ENT = 1 << ADDR_W;

    generate
        if (PIXEL_WIDTH != X_WIDTH + Y_WIDTH + DEPTH_WIDTH + COLOR_WIDTH) begin : g_bad_pixel_width
            $error("z_buffer_stage: PIXEL_WIDTH must equal X_WIDTH+Y_WIDTH+DEPTH_WIDTH+COLOR_WIDTH");
        end
    endgenerate

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    // Cleared entry: farthest possible depth, black.
    localparam logic [ENT_W-1:0] CLEAR_ENT = {{DEPTH_WIDTH{1'b1}}, {COLOR_WIDTH{1'b0}}};

    logic [ENT_W-1:0] mem [0:NUM_ENT-1];

    logic [1:0]             state_q, state_d;
    logic [ADDR_W-1:0]      clr_addr_q, clr_addr_d;
    logic                   clear_pending_q, clear_pending_d;
    logic                   drop_err_q;
    logic                   rd_valid_q;
    logic [DEPTH_WIDTH-1:0] rd_depth_q;
    logic [COLOR_WIDTH-1:0] rd_color_q;

    // In-flight pixel and the depth currently stored at its address.
    logic [ADDR_W-1:0]      pix_addr_q;
    logic [DEPTH_WIDTH-1:0] pix_depth_q;
    logic [COLOR_WIDTH-1:0] pix_color_q;
    logic [DEPTH_WIDTH-1:0] stored_depth_q;

    logic [ADDR_W-1:0]      in_addr;
    logic [DEPTH_WIDTH-1:0] in_depth;
    logic [COLOR_WIDTH-1:0] in_color;

    logic                   accept;
    logic                   closer;
    logic                   start_clear;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [ENT_W-1:0]       wr_data;

    // x sits in the MSBs, so the top ADDR_W bits are already the {x,y} address.
    assign in_addr  = pix_in[PIXEL_WIDTH-1 -: ADDR_W];
    assign in_depth = pix_in[ENT_W-1 -: DEPTH_WIDTH];
    assign in_color = pix_in[COLOR_WIDTH-1:0];

    assign rdy_z_buffer = (state_q == ST_IDLE);
    assign clear_busy   = (state_q == ST_CLEAR);
    assign accept       = rdy_z_buffer && send_z_buffer;
    // Strictly closer only: a tie keeps the pixel that got there first.
    assign closer       = (pix_depth_q < stored_depth_q);

    always_comb begin
        state_d         = state_q;
        clr_addr_d      = clr_addr_q;
        clear_pending_d = clear_pending_q;
        start_clear     = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = clr_addr_q;
        wr_data         = CLEAR_ENT;
        case (state_q)
            ST_CLEAR: begin
                // clear_req here is ignored: the running sweep is not restarted.
                wr_en      = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (send_z_buffer) begin
                    state_d         = ST_LOOKUP;
                    clear_pending_d = clear_req;
                end else if (clear_req) begin
                    state_d     = ST_CLEAR;
                    start_clear = 1'b1;
                end
            end
            ST_LOOKUP: begin
                state_d = ST_UPDATE;
                if (clear_req) begin
                    clear_pending_d = 1'b1;
                end
            end
            ST_UPDATE: begin
                if (closer) begin
                    wr_en   = 1'b1;
                    wr_addr = pix_addr_q;
                    wr_data = {pix_depth_q, pix_color_q};
                end
                // A request landing in this last cycle is honoured immediately.
                if (clear_pending_q || clear_req) begin
                    state_d     = ST_CLEAR;
                    start_clear = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
                clear_pending_d = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        if (start_clear) begin
            clr_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_CLEAR;
            clr_addr_q      <= '0;
            clear_pending_q <= 1'b0;
            drop_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_addr_q      <= clr_addr_d;
            clear_pending_q <= clear_pending_d;
            if (send_z_buffer && !rdy_z_buffer) begin
                drop_err_q <= 1'b1;
            end
        end
    end

    // Storage and the lookup path carry no reset; an in-flight pixel is
    // abandoned by the state machine returning to CLEAR.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (accept) begin
            pix_addr_q     <= in_addr;
            pix_depth_q    <= in_depth;
            pix_color_q    <= in_color;
            stored_depth_q <= mem[in_addr][ENT_W-1 -: DEPTH_WIDTH];
        end
    end

    // Readout port: reads sample the array before this edge's write lands,
    // so a same-address collision returns the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_depth_q <= '0;
            rd_color_q <= '0;
        end else if (rd_en && (state_q != ST_CLEAR)) begin
            rd_valid_q <= 1'b1;
            rd_depth_q <= mem[rd_addr][ENT_W-1 -: DEPTH_WIDTH];
            rd_color_q <= mem[rd_addr][COLOR_WIDTH-1:0];
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign drop_err = drop_err_q;
    assign rd_valid = rd_valid_q;
    assign rd_depth = rd_depth_q;
    assign rd_color = rd_color_q;

`ifdef ZBUF_STATS_EN
    logic [15:0] stat_written_q;
    logic [15:0] stat_rejected_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_written_q  <= '0;
            stat_rejected_q <= '0;
        end else if (start_clear) begin
            // Zeroing wins over the final UPDATE count of a pixel that requested the clear.
            stat_written_q  <= '0;
            stat_rejected_q <= '0;
        end else if (state_q == ST_UPDATE) begin
            if (closer) begin
                if (stat_written_q != 16'hFFFF) begin
                    stat_written_q <= stat_written_q + 16'd1;
                end
            end else begin
                if (stat_rejected_q != 16'hFFFF) begin
                    stat_rejected_q <= stat_rejected_q + 16'd1;
                end
            end
        end
    end

    assign stat_written  = stat_written_q;
    assign stat_rejected = stat_rejected_q;
`endif

endmodule
